// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the packet stream demultiplexer.
package stream_demux_pkg;

    // Packet-level routing state.
    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DROP
    } demux_state_t;

    // Selector width for a given port count; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry output register: holds a single beat (valid, data, last) per port.
module stream_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o,
    output logic         free_o
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;
    logic         last_d, last_q;

    // Next-state: a load wins over a drain so drain+load keeps the slot full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Outputs; the slot can take a beat if empty or being drained this cycle.
    always_comb begin
        valid_o = valid_q;
        data_o  = data_q;
        last_o  = last_q;
        free_o  = !valid_q || ready_i;
    end

endmodule

// File: rtl/stream_demux.sv
// Packet-level demultiplexer: routes one valid/ready stream to one of N_OUT ports,
// destination taken from the first beat and held to the last beat.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned  N_OUT = 4,
    parameter int unsigned  W     = 8,
    localparam int unsigned SEL_W = sel_width(N_OUT)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [W-1:0]              in_data_i,
    input  logic                      in_last_i,
    input  logic [SEL_W-1:0]          in_sel_i,
    output logic [N_OUT-1:0]          out_valid_o,
    input  logic [N_OUT-1:0]          out_ready_i,
    output logic [N_OUT-1:0][W-1:0]   out_data_o,
    output logic [N_OUT-1:0]          out_last_o,
    output logic                      busy_o,
    output logic                      drop_o
);

    demux_state_t     state_d, state_q;
    logic [SEL_W-1:0] dest_d, dest_q;
    logic             drop_d, drop_q;

    logic [SEL_W-1:0] target;
    logic             tgt_hit;
    logic             tgt_free;
    logic             is_drop;
    logic             hs;
    logic [N_OUT-1:0] slot_load;
    logic [N_OUT-1:0] slot_free;

    // Destination decode and input handshake; only the addressed slot gates in_ready.
    always_comb begin
        target    = (state_q == IDLE) ? in_sel_i : dest_q;
        tgt_hit   = 1'b0;
        tgt_free  = 1'b0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            if (target == SEL_W'(i)) begin
                tgt_hit  = 1'b1;
                tgt_free = slot_free[i];
            end
        end
        // Nonexistent ports are only reachable from IDLE; DROP carries that decision on.
        is_drop    = (state_q == DROP) || !tgt_hit;
        in_ready_o = is_drop || tgt_free;
        hs         = in_valid_i && in_ready_o;
        slot_load  = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            slot_load[i] = hs && !is_drop && (target == SEL_W'(i));
        end
    end

    // FSM next-state, destination latch and drop pulse.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        drop_d  = hs && is_drop;
        unique case (state_q)
            IDLE: begin
                if (hs && !in_last_i) begin
                    dest_d  = in_sel_i;
                    state_d = tgt_hit ? ROUTE : DROP;
                end
            end
            ROUTE, DROP: begin
                if (hs && in_last_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, destination and drop registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            dest_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            drop_q  <= drop_d;
        end
    end

    // Status outputs decoded from registered state.
    always_comb begin
        busy_o = (state_q != IDLE);
        drop_o = drop_q;
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        stream_slot #(
            .W (W)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .load_i  (slot_load[g]),
            .data_i  (in_data_i),
            .last_i  (in_last_i),
            .ready_i (out_ready_i[g]),
            .valid_o (out_valid_o[g]),
            .data_o  (out_data_o[g]),
            .last_o  (out_last_o[g]),
            .free_o  (slot_free[g])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: scoreboard on a 4-port instance plus
// directed drop checks on a 3-port instance.
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst_n;

    // 4-port instance
    logic            in_valid4, in_ready4, in_last4;
    logic [7:0]      in_data4;
    logic [1:0]      in_sel4;
    logic [3:0]      out_valid4, out_ready4, out_last4;
    logic [3:0][7:0] out_data4;
    logic            busy4, drop4;

    // 3-port instance
    logic            in_valid3, in_ready3, in_last3;
    logic [7:0]      in_data3;
    logic [1:0]      in_sel3;
    logic [2:0]      out_valid3, out_ready3, out_last3;
    logic [2:0][7:0] out_data3;
    logic            busy3, drop3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] sb_q [4][$];
    logic [8:0] exp_beat;
    bit         mon_en  = 1'b0;
    bit         rand_en = 1'b0;
    int         m_dest  = 0;
    bit         m_busy  = 1'b0;
    int         w;
    logic [7:0] t1_data [4];

    stream_demux #(.N_OUT(4), .W(8)) u_dut4 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid4),
        .in_ready_o  (in_ready4),
        .in_data_i   (in_data4),
        .in_last_i   (in_last4),
        .in_sel_i    (in_sel4),
        .out_valid_o (out_valid4),
        .out_ready_i (out_ready4),
        .out_data_o  (out_data4),
        .out_last_o  (out_last4),
        .busy_o      (busy4),
        .drop_o      (drop4)
    );

    stream_demux #(.N_OUT(3), .W(8)) u_dut3 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid3),
        .in_ready_o  (in_ready3),
        .in_data_i   (in_data3),
        .in_last_i   (in_last3),
        .in_sel_i    (in_sel3),
        .out_valid_o (out_valid3),
        .out_ready_i (out_ready3),
        .out_data_o  (out_data3),
        .out_last_o  (out_last3),
        .busy_o      (busy3),
        .drop_o      (drop3)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one beat into the 4-port DUT, wait for acceptance, update the model.
    task automatic send4(input logic [1:0] sel, input logic [7:0] data, input logic last,
                         output int waits);
        in_valid4 = 1'b1;
        in_sel4   = sel;
        in_data4  = data;
        in_last4  = last;
        waits     = 0;
        forever begin
            @(negedge clk);
            if (in_ready4) break;
            waits++;
            if (waits > 200) begin
                check_eq("hs_timeout", 32'(in_ready4), 32'd1);
                in_valid4 = 1'b0;
                return;
            end
        end
        if (!m_busy) m_dest = int'(sel);
        sb_q[m_dest].push_back({last, data});
        m_busy = !last;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every consumed beat must match the head of its port queue.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid4[i] && out_ready4[i]) begin
                    check_eq($sformatf("sb_has_p%0d", i), 32'(sb_q[i].size() != 0), 32'd1);
                    if (sb_q[i].size() != 0) begin
                        exp_beat = sb_q[i].pop_front();
                        check_eq($sformatf("sb_beat_p%0d", i),
                                 32'({out_last4[i], out_data4[i]}), 32'(exp_beat));
                    end
                end
            end
        end
    end

    // Random consumer readiness on ports 0/1 during the soak.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) out_ready4 = {2'b11, 2'($urandom_range(0, 3))};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t1_data[0] = 8'h11; t1_data[1] = 8'h22; t1_data[2] = 8'h33; t1_data[3] = 8'h44;
        rst_n = 1'b0;
        in_valid4 = 1'b0; in_last4 = 1'b0; in_data4 = '0; in_sel4 = '0; out_ready4 = '0;
        in_valid3 = 1'b0; in_last3 = 1'b0; in_data3 = '0; in_sel3 = '0; out_ready3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid4), 32'd0);
        check_eq("rst_out_data", 32'(out_data4), 32'd0);
        check_eq("rst_out_last", 32'(out_last4), 32'd0);
        check_eq("rst_busy", 32'(busy4), 32'd0);
        check_eq("rst_drop", 32'(drop4), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready4), 32'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat packets to every port, one-cycle latency.
        out_ready4 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            send4(2'(i), t1_data[i], 1'b1, w);
            check_eq($sformatf("t1_valid_p%0d", i), 32'(out_valid4[i]), 32'd1);
            check_eq($sformatf("t1_data_p%0d", i), 32'(out_data4[i]), 32'(t1_data[i]));
            check_eq($sformatf("t1_last_p%0d", i), 32'(out_last4[i]), 32'd1);
            check_eq($sformatf("t1_busy_%0d", i), 32'(busy4), 32'd0);
        end
        in_valid4 = 1'b0;

        // 3-beat packet to port 2; later beats carry a different sel.
        send4(2'd2, 8'hA0, 1'b0, w);
        check_eq("t2_busy0", 32'(busy4), 32'd1);
        check_eq("t2_route0", 32'(out_valid4), 32'b0100);
        send4(2'd0, 8'hA1, 1'b0, w);
        check_eq("t2_busy1", 32'(busy4), 32'd1);
        check_eq("t2_route1", 32'(out_valid4), 32'b0100);
        send4(2'd0, 8'hA2, 1'b1, w);
        check_eq("t2_busy2", 32'(busy4), 32'd0);
        check_eq("t2_route2", 32'(out_valid4), 32'b0100);
        in_valid4 = 1'b0;

        // 3-port instance: sel 3 is nonexistent, both beats discarded.
        out_ready3 = 3'b111;
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'hD0; in_last3 = 1'b0;
        @(negedge clk);
        check_eq("t3_ready0", 32'(in_ready3), 32'd1);
        @(posedge clk);
        #1;
        check_eq("t3_drop0", 32'(drop3), 32'd1);
        check_eq("t3_busy0", 32'(busy3), 32'd1);
        check_eq("t3_nov0", 32'(out_valid3), 32'd0);
        in_data3 = 8'hD1; in_last3 = 1'b1;
        @(negedge clk);
        check_eq("t3_ready1", 32'(in_ready3), 32'd1);
        @(posedge clk);
        #1;
        check_eq("t3_drop1", 32'(drop3), 32'd1);
        check_eq("t3_busy1", 32'(busy3), 32'd0);
        check_eq("t3_nov1", 32'(out_valid3), 32'd0);
        in_sel3 = 2'd1; in_data3 = 8'h77; in_last3 = 1'b1;
        @(negedge clk);
        check_eq("t3_ready2", 32'(in_ready3), 32'd1);
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        check_eq("t3_drop2", 32'(drop3), 32'd0);
        check_eq("t3_route_v", 32'(out_valid3), 32'b010);
        check_eq("t3_route_d", 32'(out_data3[1]), 32'h77);
        check_eq("t3_route_l", 32'(out_last3[1]), 32'd1);

        // Stall on port 1 while port 0 drains independently.
        out_ready4 = 4'b0000;
        send4(2'd0, 8'h50, 1'b1, w);
        send4(2'd1, 8'hB0, 1'b0, w);
        in_valid4 = 1'b1; in_sel4 = 2'd1; in_data4 = 8'hB1; in_last4 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("t4_stall_rdy%0d", c), 32'(in_ready4), 32'd0);
            check_eq($sformatf("t4_hold_v%0d", c), 32'(out_valid4[1]), 32'd1);
            check_eq($sformatf("t4_hold_d%0d", c), 32'(out_data4[1]), 32'hB0);
            @(posedge clk);
            #1;
            if (c == 1) out_ready4 = 4'b0001;
        end
        check_eq("t4_p0_drained", 32'(out_valid4[0]), 32'd0);
        out_ready4 = 4'b0011;
        send4(2'd1, 8'hB1, 1'b0, w);
        check_eq("t4_thru1", 32'(w), 32'd0);
        send4(2'd1, 8'hB2, 1'b0, w);
        check_eq("t4_thru2", 32'(w), 32'd0);
        send4(2'd1, 8'hB3, 1'b1, w);
        check_eq("t4_thru3", 32'(w), 32'd0);
        in_valid4 = 1'b0;

        // Reset mid-packet after beat 2 of 4 to port 3.
        out_ready4 = 4'hF;
        send4(2'd3, 8'hC0, 1'b0, w);
        send4(2'd3, 8'hC1, 1'b0, w);
        in_valid4  = 1'b0;
        out_ready4 = 4'h0;
        check_eq("t5_pre_valid", 32'(out_valid4[3]), 32'd1);
        check_eq("t5_pre_busy", 32'(busy4), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", 32'(out_valid4), 32'd0);
        check_eq("t5_rst_busy", 32'(busy4), 32'd0);
        for (int i = 0; i < 4; i++) sb_q[i].delete();
        m_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 4'hF;
        send4(2'd0, 8'h5A, 1'b1, w);
        check_eq("t5_after_v", 32'(out_valid4), 32'b0001);
        check_eq("t5_after_d", 32'(out_data4[0]), 32'h5A);
        in_valid4 = 1'b0;

        // Soak: alternating single-beat packets with random consumer readiness.
        rand_en = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            send4(2'(k % 2), 8'($urandom), 1'b1, w);
        end
        in_valid4 = 1'b0;
        rand_en   = 1'b0;
        @(posedge clk);
        #2;
        out_ready4 = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("sb_drained_p%0d", i), 32'(sb_q[i].size()), 32'd0);
        end
        check_eq("end_idle", 32'(busy4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
# stream_demux

Packet-level stream demultiplexer: one valid/ready input stream is routed to one of `N_OUT` valid/ready output streams. The destination is taken from the first beat of each packet and held until its `in_last` beat. Packets addressed to a nonexistent port are accepted and discarded. It is the receive-side counterpart of the team's select-based mux: sits after a shared link and fans traffic out to per-channel consumers, with one register slot per output.

## Interface
- `N_OUT`, 4: number of output ports, ≥2.
- `W`, 8: data width in bits.
- `SEL_W`, `$clog2(N_OUT)`: selector width (derived localparam, not overridable).

- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when high together with `in_valid`.
- `in_data`  in  W  input payload.
- `in_last`  in  1  final beat of packet.
- `in_sel`  in  SEL_W  destination; sampled only on the first beat of a packet.
- `out_valid`  out  N_OUT  per-port beat valid.
- `out_ready`  in  N_OUT  per-port consumer ready.
- `out_data`  out  N_OUT×W  per-port payload (packed array `[N_OUT-1:0][W-1:0]`).
- `out_last`  out  N_OUT  per-port last flag.
- `busy`  out  1  high while in mid-packet (ROUTE or DROP).
- `drop`  out  1  one-cycle pulse per discarded beat.

## Operation
- Three states: IDLE, ROUTE, DROP.
- IDLE:
  - The destination is `in_sel` of the current beat, used combinationally.
  - If `in_sel < N_OUT`, `in_ready` = slot[in_sel] is empty, or its `out_ready` is high this cycle.
  - If `in_sel >= N_OUT`, `in_ready` = 1, the beat is discarded and `drop` pulses.
  - On handshake with `in_last`=0, latch `dest`. Go to ROUTE for a valid `in_sel`, otherwise DROP.
  - On handshake with `in_last`=1 (single-beat packet), stay in IDLE.
- ROUTE:
  - `in_sel` is ignored. `in_ready` follows slot[`dest`] under the same rule as IDLE.
  - On handshake with `in_last`=1, go to IDLE.
- DROP:
  - `in_ready` = 1. Every accepted beat is discarded and pulses `drop`.
  - On handshake with `in_last`=1, go to IDLE.
- Output slots, one per port:
  - Each slot is a single register holding valid, data and last.
  - Loaded on an input handshake targeting that port.
  - Cleared on `out_valid & out_ready` unless reloaded in the same cycle; simultaneous drain and load keeps valid high with the new beat.
- Only the addressed slot's `out_ready` affects `in_ready`. Other ports drain independently.
- Beat order within a packet is preserved. Packets are never interleaved across ports, because a new packet starts only after the previous `in_last` is accepted.
- `in_ready` does not depend on `in_valid`. It does depend combinationally on `out_ready[dest]`.

## Timing
- Latency is 1 cycle: a beat accepted at edge k gives `out_valid[dest]`=1 after edge k.
- Full throughput of 1 beat/cycle to a port whose consumer holds `out_ready`=1.
- A stalled port (`out_ready`=0 with its slot full) holds `in_ready`=0. Input `data`/`last`/`sel` must stay stable while `in_valid`=1 and `in_ready`=0. `out_*` of a stalled slot holds stable.
- Reset values (async assert, sync release): state IDLE, all `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `drop`=0, `dest`=0.
- Reset mid-packet: slot contents are lost and the next beat after release is treated as a first beat.
- `drop` is registered: it is high in the cycle after the discarded beat's handshake.
- `busy` is registered from the state: it is high in the cycle after the first-beat handshake of a multi-beat packet, and low in the cycle after the last-beat handshake.

## Structure
- `stream_demux_pkg`: `typedef enum logic [1:0] {IDLE, ROUTE, DROP} demux_state_t`.
- Sub-module `stream_slot` (params `W`): one-entry register with load, valid/ready and last. Instantiated `N_OUT` times in a generate loop.
- The top level holds the FSM, the `dest` register, `in_ready` selection and the `drop` register.

## Test plan
- Single-beat packets with `N_OUT`=4, sel 0,1,2,3 and data 0x11,0x22,0x33,0x44, all `out_ready`=1 → each port shows its byte exactly one cycle after acceptance, with `out_last`=1, and `busy` stays 0.
- 3-beat packet, first-beat `in_sel`=2, later beats with `in_sel`=0, data 0xA0,0xA1,0xA2 → all three beats appear on port 2 only, `busy`=1 for 2 cycles, then IDLE.
- `N_OUT`=3, 2-beat packet with `in_sel`=3 → `in_ready`=1 on both beats, `drop` pulses twice, no `out_valid` asserts, and the next packet with sel=1 is routed normally.
- Port 1 holds `out_ready`=0 while a 4-beat packet targets it → 1 beat is buffered, `in_ready`=0 until `out_ready` rises, then 1 beat/cycle with order preserved. Port 0 keeps draining its own earlier beat during the stall.
- `rst_n` pulsed low mid-packet (after beat 2 of 4 to port 3) → all `out_valid` drop to 0 immediately, and after release a beat with `in_sel`=0 routes to port 0.
- Back-to-back single-beat packets alternating sel 0/1 with random `out_ready` → no lost or duplicated beats, and per-port order matches a scoreboard over 1000 beats.
